point_update_sequencer: RTL

Frame-level initiator for the `update_point` engine in the squishy-car soft-body simulator. Holds the position and velocity of every mass point in an internal register file. On each frame start it walks points 0..NUM_POINTS-1: it presents each point to `update_point`, pulses begin, waits for `result_out`, and writes the returned state back in place. It also exposes an asynchronous read port so the renderer can fetch positions between sweeps.

---
 rtl/point_pkg.sv | 28 ++
 rtl/point_regfile.sv | 40 ++++
 rtl/point_update_sequencer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/point_pkg.sv
`default_nettype none
// point_pkg: shared types for the point update sequencer (point record, sequencer states, index sizing).
package point_pkg;

  localparam int PT_POS_W = 8;
  localparam int PT_VEL_W = 8;

  // Field order matches the packed layout used by the register file: {pos_x, pos_y, vel_x, vel_y}.
  typedef struct packed {
    logic [PT_POS_W-1:0] pos_x;
    logic [PT_POS_W-1:0] pos_y;
    logic [PT_VEL_W-1:0] vel_x;
    logic [PT_VEL_W-1:0] vel_y;
  } point_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/point_regfile.sv
`default_nettype none
// point_regfile: NUM_POINTS packed point records, reset-cleared, one synchronous write port and two
// asynchronous read ports (full record for the active point, position-only for the renderer).
module point_regfile
  import point_pkg::*;
#(
  parameter int NUM_POINTS = 16,
  parameter int IDX_W      = 4,
  parameter int DATA_W     = 32,
  parameter int RD1_W      = 16
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              we_in,
  input  logic [IDX_W-1:0]  wr_idx_in,
  input  logic [DATA_W-1:0] wr_data_in,
  input  logic [IDX_W-1:0]  rd0_idx_in,
  output logic [DATA_W-1:0] rd0_data_out,
  input  logic [IDX_W-1:0]  rd1_idx_in,
  output logic [RD1_W-1:0]  rd1_data_out
);

  logic [DATA_W-1:0] mem_q [NUM_POINTS];

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < NUM_POINTS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_in && (int'(wr_idx_in) < NUM_POINTS)) begin
      mem_q[wr_idx_in] <= wr_data_in;
    end
  end

  // Indices beyond NUM_POINTS (non power-of-two sizes) read as zero.
  assign rd0_data_out = (int'(rd0_idx_in) < NUM_POINTS) ? mem_q[rd0_idx_in] : '0;
  assign rd1_data_out = (int'(rd1_idx_in) < NUM_POINTS) ? mem_q[rd1_idx_in][DATA_W-1 -: RD1_W] : '0;

endmodule
`default_nettype wire

// File: rtl/point_update_sequencer.sv
`default_nettype none
// point_update_sequencer: walks every mass point through update_point once per frame, writing results back in place.
// Optional: define UPDATE_TIMEOUT_EN to bound each WAIT by MAX_WAIT cycles and report timeout_out.
module point_update_sequencer
  import point_pkg::*;
#(
  parameter int POSITION_SIZE = 8,
  parameter int VELOCITY_SIZE = 8,
  parameter int NUM_POINTS    = 16,
  parameter int MAX_WAIT      = 255,
  localparam int IDX_W        = idx_width(NUM_POINTS)
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     frame_start_in,
  input  logic                     init_valid_in,
  input  logic [IDX_W-1:0]         init_idx_in,
  input  logic [POSITION_SIZE-1:0] init_pos_x_in,
  input  logic [POSITION_SIZE-1:0] init_pos_y_in,
  input  logic [VELOCITY_SIZE-1:0] init_vel_x_in,
  input  logic [VELOCITY_SIZE-1:0] init_vel_y_in,
  output logic                     upd_begin_out,
  output logic [POSITION_SIZE-1:0] upd_pos_x_out,
  output logic [POSITION_SIZE-1:0] upd_pos_y_out,
  output logic [VELOCITY_SIZE-1:0] upd_vel_x_out,
  output logic [VELOCITY_SIZE-1:0] upd_vel_y_out,
  input  logic                     upd_result_in,
  input  logic [POSITION_SIZE-1:0] upd_new_pos_x_in,
  input  logic [POSITION_SIZE-1:0] upd_new_pos_y_in,
  input  logic [VELOCITY_SIZE-1:0] upd_new_vel_x_in,
  input  logic [VELOCITY_SIZE-1:0] upd_new_vel_y_in,
  input  logic [IDX_W-1:0]         rd_idx_in,
  output logic [POSITION_SIZE-1:0] rd_pos_x_out,
  output logic [POSITION_SIZE-1:0] rd_pos_y_out,
  output logic                     busy_out,
  output logic                     frame_done_out,
  output logic                     timeout_out
);

  localparam int POS2_W = 2 * POSITION_SIZE;
  localparam int DATA_W = POS2_W + 2 * VELOCITY_SIZE;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_POINTS - 1);

  seq_state_t        state_q;
  logic [IDX_W-1:0]  idx_q;
  logic              begin_q;
  logic              busy_q;
  logic              done_q;

  logic              init_wr;
  logic              accept_result;
  logic              expire;
  logic              advance;
  logic              we;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] cur_data;
  logic [POS2_W-1:0] rd_pos;

  assign init_wr       = (state_q == IDLE) && init_valid_in;
  assign accept_result = (state_q == WAIT) && upd_result_in;
  assign advance       = accept_result || expire;

  assign we      = init_wr || accept_result;
  assign wr_idx  = init_wr ? init_idx_in : idx_q;
  assign wr_data = init_wr
                 ? {init_pos_x_in, init_pos_y_in, init_vel_x_in, init_vel_y_in}
                 : {upd_new_pos_x_in, upd_new_pos_y_in, upd_new_vel_x_in, upd_new_vel_y_in};

`ifdef UPDATE_TIMEOUT_EN
  localparam int WCNT_W = $clog2(MAX_WAIT + 1);

  logic [WCNT_W-1:0] wcnt_q;
  logic              timeout_q;

  // The MAX_WAIT-th silent WAIT cycle gives up on the current point.
  assign expire = (state_q == WAIT) && !upd_result_in && (wcnt_q == WCNT_W'(MAX_WAIT - 1));

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_q == ISSUE) begin
        wcnt_q <= '0;
      end else if (state_q == WAIT) begin
        wcnt_q <= wcnt_q + 1'b1;
      end
      if ((state_q == IDLE) && frame_start_in) begin
        timeout_q <= 1'b0;
      end else if (expire) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign timeout_out = timeout_q;
`else
  assign expire      = 1'b0;
  assign timeout_out = 1'b0;
`endif

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      idx_q   <= '0;
      begin_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (frame_start_in) begin
            state_q <= ISSUE;
            idx_q   <= '0;
            begin_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ISSUE: begin
          state_q <= WAIT;
          begin_q <= 1'b0;
        end
        WAIT: begin
          if (advance) begin
            if (idx_q == LAST_IDX) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ISSUE;
              idx_q   <= idx_q + 1'b1;
              begin_q <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          begin_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  point_regfile #(
    .NUM_POINTS (NUM_POINTS),
    .IDX_W      (IDX_W),
    .DATA_W     (DATA_W),
    .RD1_W      (POS2_W)
  ) u_regfile (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .we_in        (we),
    .wr_idx_in    (wr_idx),
    .wr_data_in   (wr_data),
    .rd0_idx_in   (idx_q),
    .rd0_data_out (cur_data),
    .rd1_idx_in   (rd_idx_in),
    .rd1_data_out (rd_pos)
  );

  assign {upd_pos_x_out, upd_pos_y_out, upd_vel_x_out, upd_vel_y_out} = cur_data;
  assign {rd_pos_x_out, rd_pos_y_out} = rd_pos;

  assign upd_begin_out  = begin_q;
  assign busy_out       = busy_q;
  assign frame_done_out = done_q;

endmodule
`default_nettype wire
